// File: rtl/e_muldiv_unit.sv
// e_muldiv_unit: Execute-stage multiply/divide unit owning HI/LO, with fixed multi-cycle latency.
// Define MULDIV_MADD_EN to enable the MADD/MSUB accumulate operations (codes 4 and 5).
module e_muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MAD_start,
    input  logic [2:0]  MAD_sel,
    input  logic        HI_En,
    input  logic        LO_En,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MSUB  = 3'd5;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [3:0]         cnt_p0;
    logic [2:0]         op_p0;
    logic [31:0]        a_p0, b_p0;
    logic [31:0]        hi_q, lo_q;
    logic               legal_op, accept, commit;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [63:0]        res;
    logic               res_wr;

    // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with zero remainder.
    function automatic logic [63:0] sdiv(input logic [31:0] n, input logic [31:0] d);
        logic [31:0] nm, dm, qm, rm, q, r;
        nm = n[31] ? (~n + 32'd1) : n;
        dm = d[31] ? (~d + 32'd1) : d;
        qm = (dm == 32'd0) ? 32'd0 : nm / dm;
        rm = (dm == 32'd0) ? 32'd0 : nm % dm;
        q  = (n[31] ^ d[31]) ? (~qm + 32'd1) : qm;
        r  = n[31] ? (~rm + 32'd1) : rm;
        return {r, q};
    endfunction

    function automatic logic [63:0] udiv(input logic [31:0] n, input logic [31:0] d);
        logic [31:0] q, r;
        q = (d == 32'd0) ? 32'd0 : n / d;
        r = (d == 32'd0) ? 32'd0 : n % d;
        return {r, q};
    endfunction

    always_comb begin
        legal_op = 1'b0;
        case (MAD_sel)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: legal_op = 1'b1;
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MSUB:                   legal_op = 1'b1;
`endif
            default:                            legal_op = 1'b0;
        endcase
    end

    assign accept = (state == IDLE) && MAD_start && legal_op;
    assign commit = (state == BUSY) && (cnt_p0 == 4'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (commit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == BUSY);
    end

    // Stage p0: operands and op latched on the accepted start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_p0 <= 4'd0;
            op_p0  <= 3'd0;
            a_p0   <= 32'd0;
            b_p0   <= 32'd0;
        end else if (accept) begin
            cnt_p0 <= ((MAD_sel == OP_DIV) || (MAD_sel == OP_DIVU)) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            op_p0  <= MAD_sel;
            a_p0   <= A;
            b_p0   <= B;
        end else if (state == BUSY) begin
            cnt_p0 <= cnt_p0 - 4'd1;
        end
    end

    assign prod_s = $signed({{32{a_p0[31]}}, a_p0}) * $signed({{32{b_p0[31]}}, b_p0});
    assign prod_u = {32'd0, a_p0} * {32'd0, b_p0};

    // Result stage: evaluated combinationally from p0 and consumed on the commit edge.
    always_comb begin
        res    = 64'd0;
        res_wr = 1'b0;
        case (op_p0)
            OP_MULT:  begin res = $unsigned(prod_s); res_wr = 1'b1; end
            OP_MULTU: begin res = prod_u;            res_wr = 1'b1; end
            OP_DIV:   begin res = sdiv(a_p0, b_p0);  res_wr = |b_p0; end
            OP_DIVU:  begin res = udiv(a_p0, b_p0);  res_wr = |b_p0; end
`ifdef MULDIV_MADD_EN
            OP_MADD:  begin res = {hi_q, lo_q} + $unsigned(prod_s); res_wr = 1'b1; end
            OP_MSUB:  begin res = {hi_q, lo_q} - $unsigned(prod_s); res_wr = 1'b1; end
`endif
            default:  begin res = 64'd0; res_wr = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (commit) begin
            if (res_wr) begin
                hi_q <= res[63:32];
                lo_q <= res[31:0];
            end
        end else if ((state == IDLE) && !MAD_start) begin
            if (HI_En) hi_q <= A;
            if (LO_En) lo_q <= A;
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;

endmodule

// File: doc/e_muldiv_unit.md
Name: e_muldiv_unit

Overview:
- Multiply/divide unit in the Execute stage, directly downstream of the ID/EX pipeline register.
- Consumes that register's E_MAD_start, E_MAD_sel, E_HI_En, E_LO_En and forwarded rs/rt operands.
- Holds the architectural HI/LO registers and models multi-cycle mult/div latency via a busy counter.
- Its busy/start outputs feed the hazard unit, which stalls later mult/div/mfhi/mflo/mthi/mtlo instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD/MSUB when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- A  input  32  forwarded rs operand
- B  input  32  forwarded rt operand
- MAD_start  input  1  one-cycle start pulse for mult/div
- MAD_sel  input  3  op: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MSUB; others no-op
- HI_En  input  1  mthi: HI <= A
- LO_En  input  1  mtlo: LO <= A
- busy  output  1  operation in flight
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, counter=0, busy=0, HI=0, LO=0, latched operands/op=0. An in-flight operation is abandoned; no result is committed.
- States:
  - IDLE: MAD_start=1 with a legal op latches A, B and MAD_sel. Counter loads MULT_CYCLES (ops 0,1,4,5) or DIV_CYCLES (ops 2,3). Next state BUSY.
  - Illegal op, or MADD/MSUB with the feature compiled out: start is ignored and the unit stays IDLE.
  - BUSY: busy=1 and counter decrements each cycle. On the edge where counter==1, HI/LO are committed, state returns to IDLE and busy falls the same edge.
- Latency: busy is 1 for exactly N cycles starting the cycle after the start edge (N = MULT_CYCLES or DIV_CYCLES). New HI/LO are visible in the first cycle with busy=0.
- Arithmetic, computed from the latched operands:
  - MULT: {HI,LO} = signed(A) * signed(B), 64-bit.
  - MULTU: {HI,LO} = unsigned product, 64-bit.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (B==0): the operation still takes DIV_CYCLES with busy=1, but HI/LO are left unchanged at commit.
- mthi/mtlo: in IDLE with no start, HI_En=1 sets HI<=A next edge and LO_En=1 sets LO<=A; both may be asserted together.
- HI_En/LO_En are ignored while BUSY or in the same cycle as MAD_start (start wins).
- MAD_start while BUSY is ignored; the in-flight op is unaffected. The hazard unit guarantees this does not occur.
- Pipeline flush does not cancel an in-flight operation; only reset does.
- HI/LO change only at reset, at commit, or on an accepted HI_En/LO_En.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined:
  - MAD_sel 4 (MADD): {HI,LO} <= {HI,LO} + signed(A)*signed(B), 64-bit wrap.
  - MAD_sel 5 (MSUB): {HI,LO} <= {HI,LO} - signed(A)*signed(B), 64-bit wrap.
  - Both take MULT_CYCLES; the accumulate uses the HI/LO values present at commit.
- Undefined: codes 4 and 5 are no-ops (no busy, HI/LO unchanged), and no 64-bit adder is synthesized.

Test Plan:
- MULT, A=0xFFFFFFFE (-2), B=3, start one cycle -> busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV, A=0xFFFFFFF9 (-7), B=2 -> busy=1 for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU, A=7, B=2 -> LO=3, HI=1.
- HI=0x11, LO=0x22 preloaded via mthi/mtlo, then DIV with B=0 -> busy 10 cycles, HI=0x11, LO=0x22 after; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start MULT, pulse reset low at cycle 3 of busy -> busy=0, HI=LO=0 immediately (asynchronously); no later commit.
- While busy, assert HI_En with A=0xDEAD and a second MAD_start -> both ignored; first op's result commits at the expected cycle; HI_En in IDLE with A=0xBEEF -> HI=0xBEEF next cycle.
- With MULDIV_MADD_EN: HI=0, LO=10, MADD A=3, B=4 -> LO=22, HI=0; MSUB A=5, B=5 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Without the macro: same stimulus -> busy stays 0 and HI/LO unchanged.
